rename_alloc_ctrl: RTL

Rename-stage controller that sequences the rename map table and owns the physical-register free list.
- Accepts one decoded instruction at a time and reads its source mappings from the map table.
- For a destination write, reads the old mapping of rd, pops a free physical register and writes the new mapping.
- Emits the renamed instruction through a valid/ready handshake.
- Commit logic returns retired physical registers to the free list through a push port.

---
 rtl/rename_pkg.sv | 15 +
 rtl/phys_free_list.sv | 49 ++++
 rtl/rename_alloc_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared sizing, index types and controller state encoding for the rename stage.
package rename_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int ARCH_W   = $clog2(NUM_ARCH);
  localparam int PHYS_W   = $clog2(NUM_PHYS);
  localparam int CNT_W    = PHYS_W + 1;

  typedef logic [PHYS_W-1:0] phys_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {INIT, ACCEPT, OLD, HOLD} state_e;

endpackage

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical registers; P0 is never stored, full pushes raise a sticky flag.
module phys_free_list
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  phys_t push_phys,
  input  logic  pop,
  output phys_t head_phys,
  output cnt_t  count,
  output logic  overflow
);

  phys_t mem [NUM_PHYS];
  phys_t head;
  phys_t tail;
  logic  full;
  logic  do_push;
  logic  do_pop;

  assign full      = (count == cnt_t'(NUM_PHYS));
  assign do_push   = push && (push_phys != '0) && !full;
  assign do_pop    = pop && (count != '0);
  assign head_phys = mem[head];

  // NOTE: the storage array is deliberately not reset; head, tail and count
  // define which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_phys;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) tail <= tail + phys_t'(1);
      if (do_pop)  head <= head + phys_t'(1);
      if (push && (push_phys != '0) && full) overflow <= 1'b1;
      count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename-stage controller: fills the free list, reads source/old mappings,
// allocates a new physical rd and presents the renamed instruction downstream.
module rename_alloc_ctrl
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ARCH_W-1:0] dec_rs1,
  input  logic [ARCH_W-1:0] dec_rs2,
  input  logic [ARCH_W-1:0] dec_rd,
  input  logic              dec_rd_wen,
  output logic [ARCH_W-1:0] map_src_reg1,
  output logic [ARCH_W-1:0] map_src_reg2,
  input  logic [PHYS_W-1:0] map_src_phys1,
  input  logic [PHYS_W-1:0] map_src_phys2,
  output logic              map_allocate,
  output logic [ARCH_W-1:0] map_arch_dest,
  output logic [PHYS_W-1:0] map_new_phys,
  input  logic              free_valid,
  input  logic [PHYS_W-1:0] free_phys,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PHYS_W-1:0] out_rs1_phys,
  output logic [PHYS_W-1:0] out_rs2_phys,
  output logic [PHYS_W-1:0] out_rd_phys,
  output logic [PHYS_W-1:0] out_old_phys,
  output logic [ARCH_W-1:0] out_rd_arch,
  output logic              out_rd_wen,
  output logic [CNT_W-1:0]  free_count,
  output logic              init_done,
  output logic              overflow_err
);

  state_e state;
  phys_t  init_cnt;
  logic   fl_push;
  phys_t  fl_push_phys;
  phys_t  fl_head;
  cnt_t   fl_count;
  logic   can_pop;

  // A pop needs a non-empty list at the start of the cycle, so a register
  // returned into an empty list is only allocated on the following cycle.
  assign can_pop      = (state == OLD) && (fl_count != '0);
  assign map_allocate = can_pop && !reset;
  assign map_arch_dest = out_rd_arch;
  assign map_new_phys  = fl_head;

  // In OLD the first read port is borrowed to fetch the pre-update rd mapping.
  assign dec_ready    = (state == ACCEPT);
  assign map_src_reg1 = (state == OLD) ? out_rd_arch : dec_rs1;
  assign map_src_reg2 = dec_rs2;

  assign fl_push      = (state == INIT) || free_valid;
  assign fl_push_phys = (state == INIT) ? init_cnt : free_phys;
  assign free_count   = fl_count;

  phys_free_list u_free_list (
    .clk       (clk),
    .reset     (reset),
    .push      (fl_push),
    .push_phys (fl_push_phys),
    .pop       (map_allocate),
    .head_phys (fl_head),
    .count     (fl_count),
    .overflow  (overflow_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      init_cnt     <= phys_t'(1);
      init_done    <= 1'b0;
      out_valid    <= 1'b0;
      out_rs1_phys <= '0;
      out_rs2_phys <= '0;
      out_rd_phys  <= '0;
      out_old_phys <= '0;
      out_rd_arch  <= '0;
      out_rd_wen   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + phys_t'(1);
          if (init_cnt == phys_t'(NUM_PHYS - 1)) begin
            state     <= ACCEPT;
            init_done <= 1'b1;
          end
        end
        ACCEPT: begin
          if (dec_valid) begin
            out_rs1_phys <= map_src_phys1;
            out_rs2_phys <= map_src_phys2;
            out_rd_arch  <= dec_rd;
            out_rd_phys  <= '0;
            out_old_phys <= '0;
            out_rd_wen   <= 1'b0;
            if (dec_rd_wen && (dec_rd != '0)) begin
              state <= OLD;
            end else begin
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        OLD: begin
          out_old_phys <= map_src_phys1;
          if (can_pop) begin
            out_rd_phys <= fl_head;
            out_rd_wen  <= 1'b1;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCEPT;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
